// File: rtl/univ_shift_pkg.sv
// Shared definitions for the universal shift register: the 3-bit operation
// select type and its encodings.
package univ_shift_pkg;

   typedef logic [2:0] mode_t;

   localparam mode_t MODE_HOLD = 3'b000;
   localparam mode_t MODE_SHL  = 3'b001;
   localparam mode_t MODE_SHR  = 3'b010;
   localparam mode_t MODE_LOAD = 3'b011;
   localparam mode_t MODE_ROTL = 3'b100;
   localparam mode_t MODE_ROTR = 3'b101;

endpackage

// File: rtl/shift_word_counter.sv
// Counts shifts within a word, wraps after WIDTH shifts and emits a one-cycle
// word_done pulse on the wrap; restart (a parallel load) zeroes the count.
module shift_word_counter
   import univ_shift_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH)
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          step,
   input  logic          restart,
   output logic [CW-1:0] cnt,
   output logic          word_done
);

   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic wrap;

   assign wrap = step && (cnt == LAST);

   // word_done is re-evaluated every edge, so any cycle that does not wrap
   // (including a frozen one) drops it back to zero.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         cnt       <= '0;
         word_done <= 1'b0;
      end else begin
         word_done <= wrap && !restart;
         if (restart || wrap) begin
            cnt <= '0;
         end else if (step) begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: left/right shift, parallel load and
// word counting. Rotate modes are built only when UNIV_SHIFT_ROTATE_EN is defined.
module univ_shift_reg
   import univ_shift_pkg::*;
#(
   parameter int    WIDTH = 8,
   localparam int   CW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             sin,
   input  logic [WIDTH-1:0] pin,
   output logic [WIDTH-1:0] out,
   output logic             sout,
   output logic [CW-1:0]    cnt,
   output logic             word_done
);

   logic [WIDTH-1:0] next_out;
   logic             next_sout;
   logic             shift;
   logic             load;

   // Unlisted encodings (and rotates when not built) fall through to HOLD.
   always_comb begin
      next_out  = out;
      next_sout = sout;
      shift     = 1'b0;
      load      = 1'b0;
      case (mode)
         MODE_SHL: begin
            next_out  = {out[WIDTH-2:0], sin};
            next_sout = out[WIDTH-1];
            shift     = 1'b1;
         end
         MODE_SHR: begin
            next_out  = {sin, out[WIDTH-1:1]};
            next_sout = out[0];
            shift     = 1'b1;
         end
         MODE_LOAD: begin
            next_out = pin;
            load     = 1'b1;
         end
`ifdef UNIV_SHIFT_ROTATE_EN
         MODE_ROTL: begin
            next_out  = {out[WIDTH-2:0], out[WIDTH-1]};
            next_sout = out[WIDTH-1];
            shift     = 1'b1;
         end
         MODE_ROTR: begin
            next_out  = {out[0], out[WIDTH-1:1]};
            next_sout = out[0];
            shift     = 1'b1;
         end
`endif
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         out  <= '0;
         sout <= 1'b0;
      end else if (en) begin
         out  <= next_out;
         sout <= next_sout;
      end
   end

   shift_word_counter #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_counter (
      .clk       (clk),
      .clr       (clr),
      .step      (en && shift),
      .restart   (en && load),
      .cnt       (cnt),
      .word_done (word_done)
   );

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8) using an arithmetic
// reference model; honours UNIV_SHIFT_ROTATE_EN the same way as the design.
module tb_univ_shift_reg;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       en = 1'b0;
   logic [2:0] mode = 3'b000;
   logic       sin = 1'b0;
   logic [7:0] pin = 8'h00;
   logic [7:0] out;
   logic       sout;
   logic [2:0] cnt;
   logic       word_done;

   int checks = 0;
   int errors = 0;

   // Reference model: register value as an integer, shift count since load.
   int mOut = 0;
   int mShifts = 0;
   bit mSout = 1'b0;
   bit mWd = 1'b0;

   logic [12:0] expVec;
   logic [12:0] actVec;

   always #5 clk = ~clk;

   univ_shift_reg #(.WIDTH(8)) dut (
      .clk       (clk),
      .clr       (clr),
      .en        (en),
      .mode      (mode),
      .sin       (sin),
      .pin       (pin),
      .out       (out),
      .sout      (sout),
      .cnt       (cnt),
      .word_done (word_done)
   );

   function automatic void modelReset();
      mOut = 0;
      mShifts = 0;
      mSout = 1'b0;
      mWd = 1'b0;
   endfunction

   function automatic void modelUpdate(input bit e, input int m, input bit s, input int p);
      bit shifted;
      shifted = 1'b0;
      mWd = 1'b0;
      if (e) begin
         if (m == 1) begin
            mSout = (mOut / 128) % 2;
            mOut = (mOut * 2 + s) % 256;
            shifted = 1'b1;
         end else if (m == 2) begin
            mSout = mOut % 2;
            mOut = mOut / 2 + s * 128;
            shifted = 1'b1;
         end else if (m == 3) begin
            mOut = p;
            mShifts = 0;
         end
`ifdef UNIV_SHIFT_ROTATE_EN
         else if (m == 4) begin
            mSout = (mOut / 128) % 2;
            mOut = (mOut * 2) % 256 + mOut / 128;
            shifted = 1'b1;
         end else if (m == 5) begin
            mSout = mOut % 2;
            mOut = mOut / 2 + (mOut % 2) * 128;
            shifted = 1'b1;
         end
`endif
         if (shifted) begin
            mShifts = mShifts + 1;
            mWd = (mShifts % 8 == 0);
         end
      end
   endfunction

   function automatic logic [12:0] modelVec();
      return {8'(mOut), mSout, 3'(mShifts % 8), mWd};
   endfunction

   // Drive one cycle's inputs on the falling edge, sample 1ns after the rise.
   task automatic applyStimulus(input bit e, input logic [2:0] m, input bit s, input logic [7:0] p);
      @(negedge clk);
      en = e;
      mode = m;
      sin = s;
      pin = p;
      @(posedge clk);
      #1;
      modelUpdate(e, int'(m), s, int'(p));
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({out, sout, cnt, word_done} !== 13'd0) begin
         errors++;
         $display("[TB] FAIL reset_initial: got %h expected %h", {out, sout, cnt, word_done}, 13'd0);
      end
      @(negedge clk);
      clr = 1'b1;
      modelReset();
      applyStimulus(1'b1, 3'b011, 1'b0, 8'hA5);
      applyStimulus(1'b1, 3'b001, 1'b1, 8'h00);
      applyStimulus(1'b1, 3'b010, 1'b0, 8'h00);
      checks++;
      if ({out, sout, cnt, word_done} !== modelVec()) begin
         errors++;
         $display("[TB] FAIL reset_prerun: got %h expected %h", {out, sout, cnt, word_done}, modelVec());
      end
      #2;
      clr = 1'b0;
      #1;
      checks++;
      if ({out, sout, cnt, word_done} !== 13'd0) begin
         errors++;
         $display("[TB] FAIL reset_async: got %h expected %h", {out, sout, cnt, word_done}, 13'd0);
      end
      @(negedge clk);
      clr = 1'b1;
      modelReset();
   endtask

   task automatic test_shl_word();
      logic [7:0] bits;
      bits = 8'b11001111;
      applyStimulus(1'b1, 3'b011, 1'b0, 8'h00);
      for (int i = 7; i >= 0; i--) begin
         applyStimulus(1'b1, 3'b001, bits[i], 8'h00);
         checks++;
         if (word_done !== (i == 0)) begin
            errors++;
            $display("[TB] FAIL shl_word_done[%0d]: got %b expected %b", i, word_done, (i == 0));
         end
      end
      checks++;
      if ({out, cnt} !== {8'hCF, 3'd0}) begin
         errors++;
         $display("[TB] FAIL shl_word: got out=%h cnt=%0d expected out=cf cnt=0", out, cnt);
      end
      applyStimulus(1'b1, 3'b000, 1'b0, 8'h00);
      checks++;
      if (word_done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL shl_pulse_width: got %b expected 0", word_done);
      end
   endtask

   task automatic test_shr_load();
      logic [7:0] expSout;
      expSout = 8'b10000001;
      applyStimulus(1'b1, 3'b011, 1'b0, 8'h81);
      for (int i = 7; i >= 0; i--) begin
         applyStimulus(1'b1, 3'b010, 1'b0, 8'h00);
         checks++;
         if (sout !== expSout[i]) begin
            errors++;
            $display("[TB] FAIL shr_sout[%0d]: got %b expected %b", 7 - i, sout, expSout[i]);
         end
      end
      checks++;
      if ({out, cnt, word_done} !== {8'h00, 3'd0, 1'b1}) begin
         errors++;
         $display("[TB] FAIL shr_end: got out=%h cnt=%0d wd=%b expected out=00 cnt=0 wd=1", out, cnt, word_done);
      end
   endtask

   task automatic test_enable_freeze();
      applyStimulus(1'b1, 3'b011, 1'b0, 8'h3B);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3'b001, 1'b1, 8'h00);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 3'b001, 1'b0, 8'hFF);
         checks++;
         if ({out, sout, cnt, word_done} !== modelVec() || cnt !== 3'd3) begin
            errors++;
            $display("[TB] FAIL en_freeze[%0d]: got %h expected %h", i, {out, sout, cnt, word_done}, modelVec());
         end
      end
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 3'b001, 1'(i), 8'h00);
         checks++;
         if ({out, sout, cnt, word_done} !== modelVec()) begin
            errors++;
            $display("[TB] FAIL en_resume[%0d]: got %h expected %h", i, {out, sout, cnt, word_done}, modelVec());
         end
      end
      checks++;
      if (word_done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL en_resume_wrap: got wd=%b expected 1", word_done);
      end
   endtask

   task automatic test_load_at_wrap();
      applyStimulus(1'b1, 3'b011, 1'b0, 8'h00);
      for (int i = 0; i < 7; i++) applyStimulus(1'b1, 3'b010, 1'b1, 8'h00);
      checks++;
      if (cnt !== 3'd7) begin
         errors++;
         $display("[TB] FAIL load_wrap_pre: got cnt=%0d expected 7", cnt);
      end
      applyStimulus(1'b1, 3'b011, 1'b0, 8'h3C);
      checks++;
      if ({out, cnt, word_done} !== {8'h3C, 3'd0, 1'b0}) begin
         errors++;
         $display("[TB] FAIL load_wrap: got out=%h cnt=%0d wd=%b expected out=3c cnt=0 wd=0", out, cnt, word_done);
      end
      applyStimulus(1'b1, 3'b000, 1'b0, 8'h00);
      checks++;
      if (word_done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL load_wrap_after: got wd=%b expected 0", word_done);
      end
   endtask

   task automatic test_rotate();
      applyStimulus(1'b1, 3'b011, 1'b0, 8'h80);
      applyStimulus(1'b1, 3'b100, 1'b0, 8'h00);
      checks++;
`ifdef UNIV_SHIFT_ROTATE_EN
      if ({out, sout, cnt} !== {8'h01, 1'b1, 3'd1}) begin
         errors++;
         $display("[TB] FAIL rotl: got out=%h sout=%b cnt=%0d expected out=01 sout=1 cnt=1", out, sout, cnt);
      end
`else
      if ({out, cnt} !== {8'h80, 3'd0}) begin
         errors++;
         $display("[TB] FAIL rotl_off: got out=%h cnt=%0d expected out=80 cnt=0", out, cnt);
      end
`endif
      applyStimulus(1'b1, 3'b101, 1'b0, 8'h00);
      checks++;
      if ({out, sout, cnt, word_done} !== modelVec()) begin
         errors++;
         $display("[TB] FAIL rotr: got %h expected %h", {out, sout, cnt, word_done}, modelVec());
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 4) != 0, 3'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
         expVec = modelVec();
         actVec = {out, sout, cnt, word_done};
         checks++;
         if (actVec !== expVec) begin
            errors++;
            $display("[TB] FAIL random[%0d]: got %h expected %h", i, actVec, expVec);
         end
      end
   endtask

   initial begin
      test_reset();
      test_shl_word();
      test_shr_load();
      test_enable_freeze();
      test_load_at_wrap();
      test_rotate();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal shift register, the successor to the fixed 8-bit serial-in left shifter. Adds configurable width, left/right shift, parallel load, optional rotate, and a shift counter that flags each completed word. Sits at the serial/parallel boundary: a deserialiser on serial input, a serialiser on parallel load.

Parameters:
WIDTH, 8, register width in bits (>= 2)
CW, $clog2(WIDTH), width of shift counter (derived; not overridden)

Ports:
clk  input  1  clock, rising-edge
clr  input  1  asynchronous active-low reset
en  input  1  clock enable; 0 freezes all state
mode  input  3  operation select (encodings in package)
sin  input  1  serial data in
pin  input  WIDTH  parallel load data
out  output  WIDTH  register contents
sout  output  1  registered: last bit shifted/rotated out
cnt  output  CW  shifts since last load/wrap
word_done  output  1  one-cycle pulse: WIDTH shifts completed

Behaviour:
- Reset: clr=0 asynchronously forces out=0, sout=0, cnt=0, word_done=0. Release is synchronous to the next clk edge.
- All updates occur on rising clk when clr=1 and en=1. en=0: all state held; word_done=0.
- Modes:
  - 000 HOLD: no change.
  - 001 SHL: out <= {out[WIDTH-2:0], sin}; sout <= out[WIDTH-1].
  - 010 SHR: out <= {sin, out[WIDTH-1:1]}; sout <= out[0].
  - 011 LOAD: out <= pin; cnt <= 0; sout holds.
  - 100 ROTL / 101 ROTR: see Optional Feature.
  - 110, 111: treated as HOLD.
- Counter:
  - Each SHL/SHR (and rotate, when enabled) increments cnt.
  - At cnt==WIDTH-1, a shift wraps cnt to 0 and sets word_done=1 for exactly the next cycle.
  - Any non-wrapping cycle clears word_done.
- Latency: one clock from inputs to out/sout/cnt/word_done.
- Direction change mid-word: cnt continues counting; it does not restart.
- LOAD on the cycle cnt==WIDTH-1: LOAD wins; cnt=0, no word_done.
- clr asserted mid-word: all state zeroed immediately; the partial word is discarded.

Optional Feature:
- Macro: UNIV_SHIFT_ROTATE_EN.
- Defined:
  - ROTL: out <= {out[WIDTH-2:0], out[WIDTH-1]}; sout <= out[WIDTH-1].
  - ROTR: out <= {out[0], out[WIDTH-1:1]}; sout <= out[0].
  - Both count as shifts for cnt/word_done.
- Undefined: modes 100/101 decode as HOLD; no rotate logic is generated.

Decomposition:
- Package univ_shift_pkg: mode encoding constants MODE_HOLD, MODE_SHL, MODE_SHR, MODE_LOAD, MODE_ROTL, MODE_ROTR, and a 3-bit mode typedef.
- One sub-module, shift_word_counter: counts cnt, handles wrap, generates the word_done pulse; inputs are step and restart.

Test Plan:
- Reset: clr=0 mid-run with out=0xA5 -> out=0, cnt=0, sout=0, word_done=0 immediately, without waiting for clk.
- WIDTH=8, SHL with sin=1,1,0,0,1,1,1,1 -> out=0xCF after 8th edge; word_done=1 for one cycle; cnt=0.
- LOAD pin=0x81, then 8x SHR with sin=0 -> sout sequence 1,0,0,0,0,0,0,1; out=0x00; word_done pulses at the end.
- en=0 for 3 cycles during SHL stream -> out/cnt frozen, word_done=0; count resumes on en=1.
- LOAD on the cycle cnt=7 -> out=pin, cnt=0, no word_done pulse.
- With UNIV_SHIFT_ROTATE_EN: LOAD 0x80, ROTL once -> out=0x01, sout=1. Without the macro: out stays 0x80, cnt unchanged.
